level_sequencer: RTL and testbench
==================================

// Module: level_sequencer
// PURPOSE
//  Game-flow controller sitting above the character/platform block controller.
//  Sequences play through NUM_LEVELS levels and tracks lives and checkpoints.
//  Consumes one-cycle death/goal/checkpoint events from the character block.
//  Drives level select, spawn coordinates, respawn strobe and movement freeze back to it.
// PARAMETERS
//  NUM_LEVELS   8    levels in the game; level index 0..NUM_LEVELS-1
//  LIVES_INIT   3    lives loaded at game start (1..15)
//  DEATH_TICKS  30   tick count spent in DYING before respawn/game-over
//  CLEAR_TICKS  60   tick count spent in CLEAR before next level loads
//  SPAWN_X      304  default spawn x (10-bit) for every level
//  SPAWN_Y      220  default spawn y (10-bit) for every level
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-low reset
//  tick         in   1   one-cycle frame/slow-rate enable for timers
//  start        in   1   start/continue button, level-sensitive, edge-detected internally
//  death_evt    in   1   one-cycle pulse: character entered lava/fell out
//  goal_evt     in   1   one-cycle pulse: character reached level transition
//  cp_evt       in   1   one-cycle pulse: character touched checkpoint
//  char_x       in   10  current character x, sampled on cp_evt
//  char_y       in   10  current character y, sampled on cp_evt
//  level        out  3   current level index
//  lives        out  4   remaining lives
//  spawn_x      out  10  respawn x (checkpoint if set, else SPAWN_X)
//  spawn_y      out  10  respawn y (checkpoint if set, else SPAWN_Y)
//  respawn      out  1   one-cycle strobe: load spawn_x/spawn_y into character
//  freeze       out  1   1 = character motion inhibited
//  game_state   out  3   encoded FSM state for display/background colour
// BEHAVIOUR
//  All state updates on posedge clk; rst==0 overrides everything on that edge.
//  Reset: state=IDLE, level=0, lives=LIVES_INIT, cp_valid=0, spawn=SPAWN_X/Y,
//   respawn=0, freeze=1, timer=0. Reset mid-game returns here in one cycle.
//  States (game_state): IDLE=0 PLAY=1 DYING=2 RESPAWN=3 CLEAR=4 WIN=5 OVER=6.
//  IDLE: on start rising edge -> RESPAWN (level=0, lives=LIVES_INIT, cp_valid=0).
//  RESPAWN: exactly one cycle; respawn=1; -> PLAY next cycle.
//  PLAY: freeze=0. Priority same cycle: death_evt > goal_evt > cp_evt.
//   death_evt: lives-=1 (saturate at 0), timer=0, -> DYING.
//   goal_evt: cp_valid=0, timer=0, -> CLEAR (or WIN if level==NUM_LEVELS-1).
//   cp_evt: cp_x/cp_y <= char_x/char_y, cp_valid=1; stay PLAY.
//  DYING: timer +=1 per tick; when timer==DEATH_TICKS-1 and tick:
//   lives==0 -> OVER, else -> RESPAWN.
//  CLEAR: timer +=1 per tick; at CLEAR_TICKS-1 and tick: level+=1 -> RESPAWN.
//  WIN / OVER: hold; on start rising edge -> IDLE.
//  Events (death/goal/cp) outside PLAY are ignored, no side effects.
//  spawn_x/y combinational mux: cp_valid ? cp_x/cp_y : SPAWN_X/SPAWN_Y.
//  freeze=1 in every state except PLAY; respawn=1 only in RESPAWN.
//  Timer width ceil(log2(max(DEATH_TICKS,CLEAR_TICKS))); cleared on each state entry.
//  Latency: event in PLAY -> state change visible next cycle; respawn strobe
//   follows DYING/CLEAR exit by one cycle.
// TESTING
//  Reset then start pulse -> cycle+1 respawn=1, spawn=(304,220); cycle+2 state=PLAY, freeze=0.
//  PLAY, cp_evt with char=(500,300), later death_evt -> lives 3->2, DYING 30 ticks,
//   respawn strobe with spawn=(500,300).
//  death_evt and goal_evt same cycle at level 0 -> DYING, lives=2, level stays 0.
//  Three deaths from LIVES_INIT=3 -> after 3rd DYING state=OVER, lives=0; start -> IDLE.
//  goal_evt at level 0 after checkpoint -> CLEAR 60 ticks, level=1, spawn=(304,220);
//   goal_evt at level 7 -> WIN, level stays 7.
//  rst=0 asserted during CLEAR mid-timer -> next edge state=IDLE, level=0, freeze=1.

Source files
------------

// File: rtl/level_sequencer.sv
// Game-flow controller: walks play through the levels, counts lives, remembers the
// last checkpoint and drives respawn/freeze back to the character block.
module level_sequencer #(
    parameter int NUM_LEVELS  = 8,
    parameter int LIVES_INIT  = 3,
    parameter int DEATH_TICKS = 30,
    parameter int CLEAR_TICKS = 60,
    parameter int SPAWN_X     = 304,
    parameter int SPAWN_Y     = 220
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       death_evt,
    input  logic       goal_evt,
    input  logic       cp_evt,
    input  logic [9:0] char_x,
    input  logic [9:0] char_y,
    output logic [2:0] level,
    output logic [3:0] lives,
    output logic [9:0] spawn_x,
    output logic [9:0] spawn_y,
    output logic       respawn,
    output logic       freeze,
    output logic [2:0] game_state
);

    localparam int MAX_TICKS = (DEATH_TICKS > CLEAR_TICKS) ? DEATH_TICKS : CLEAR_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_DYING   = 3'd2,
        S_RESPAWN = 3'd3,
        S_CLEAR   = 3'd4,
        S_WIN     = 3'd5,
        S_OVER    = 3'd6
    } state_t;

    state_t        state, state_d;
    logic [2:0]    level_d;
    logic [3:0]    lives_d;
    logic [TW-1:0] timer, timer_d;
    logic [9:0]    cp_x, cp_y, cp_x_d, cp_y_d;
    logic          cp_valid, cp_valid_d;
    logic          start_q;
    logic          start_rise;

    assign start_rise = start & ~start_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            level    <= 3'd0;
            lives    <= 4'(LIVES_INIT);
            timer    <= '0;
            cp_x     <= 10'(SPAWN_X);
            cp_y     <= 10'(SPAWN_Y);
            cp_valid <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state    <= state_d;
            level    <= level_d;
            lives    <= lives_d;
            timer    <= timer_d;
            cp_x     <= cp_x_d;
            cp_y     <= cp_y_d;
            cp_valid <= cp_valid_d;
            start_q  <= start;
        end
    end

    // Timer is zeroed on every transition so each timed state starts counting from 0.
    always_comb begin
        state_d    = state;
        level_d    = level;
        lives_d    = lives;
        timer_d    = timer;
        cp_x_d     = cp_x;
        cp_y_d     = cp_y;
        cp_valid_d = cp_valid;
        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    state_d    = S_RESPAWN;
                    level_d    = 3'd0;
                    lives_d    = 4'(LIVES_INIT);
                    cp_valid_d = 1'b0;
                    timer_d    = '0;
                end
            end
            S_RESPAWN: begin
                state_d = S_PLAY;
                timer_d = '0;
            end
            S_PLAY: begin
                if (death_evt) begin
                    lives_d = (lives != 4'd0) ? lives - 4'd1 : 4'd0;
                    timer_d = '0;
                    state_d = S_DYING;
                end else if (goal_evt) begin
                    cp_valid_d = 1'b0;
                    timer_d    = '0;
                    state_d    = (level == 3'(NUM_LEVELS - 1)) ? S_WIN : S_CLEAR;
                end else if (cp_evt) begin
                    cp_x_d     = char_x;
                    cp_y_d     = char_y;
                    cp_valid_d = 1'b1;
                end
            end
            S_DYING: begin
                if (tick) begin
                    if (timer == TW'(DEATH_TICKS - 1)) begin
                        timer_d = '0;
                        state_d = (lives == 4'd0) ? S_OVER : S_RESPAWN;
                    end else begin
                        timer_d = timer + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (tick) begin
                    if (timer == TW'(CLEAR_TICKS - 1)) begin
                        timer_d = '0;
                        level_d = level + 3'd1;
                        state_d = S_RESPAWN;
                    end else begin
                        timer_d = timer + 1'b1;
                    end
                end
            end
            S_WIN, S_OVER: begin
                if (start_rise) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign spawn_x    = cp_valid ? cp_x : 10'(SPAWN_X);
    assign spawn_y    = cp_valid ? cp_y : 10'(SPAWN_Y);
    assign respawn    = (state == S_RESPAWN);
    assign freeze     = (state != S_PLAY);
    assign game_state = state;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: expected state-change records are queued by the
// stimulus and checked by a monitor each time game_state changes.
module tb_level_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_PLAY = 3'd1, ST_DYING = 3'd2,
                           ST_RESPAWN = 3'd3, ST_CLEAR = 3'd4, ST_WIN = 3'd5, ST_OVER = 3'd6;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       death_evt = 1'b0;
    logic       goal_evt = 1'b0;
    logic       cp_evt = 1'b0;
    logic [9:0] char_x = '0;
    logic [9:0] char_y = '0;
    logic [2:0] level;
    logic [3:0] lives;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic       respawn;
    logic       freeze;
    logic [2:0] game_state;

    level_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .death_evt(death_evt), .goal_evt(goal_evt), .cp_evt(cp_evt),
        .char_x(char_x), .char_y(char_y),
        .level(level), .lives(lives), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .respawn(respawn), .freeze(freeze), .game_state(game_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic [2:0] prev_state;

    // Record layout: {state, level, lives, freeze, respawn, spawn_x, spawn_y}
    function automatic logic [W-1:0] rec(input logic [2:0] st, input logic [2:0] lv,
                                         input logic [3:0] li, input logic [9:0] sx,
                                         input logic [9:0] sy);
        return {st, lv, li, (st != ST_PLAY), (st == ST_RESPAWN), sx, sy};
    endfunction

    function automatic logic [W-1:0] cur_rec();
        return {game_state, level, lives, freeze, respawn, spawn_x, spawn_y};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en && game_state !== prev_state) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_transition: state %0d -> %0d, nothing expected",
                         prev_state, game_state);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("transition", cur_rec(), e);
            end
        end
        prev_state = game_state;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        start = 1'b1; step(); start = 1'b0; step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drained(input string name);
        check(name, W'(exp_q.size()), W'(0));
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        check("reset_state", cur_rec(), rec(ST_IDLE, 3'd0, 4'd3, 10'd304, 10'd220));
        prev_state = game_state;
        mon_en = 1'b1;

        // Start: one RESPAWN cycle with default spawn, then PLAY
        exp_q.push_back(rec(ST_RESPAWN, 3'd0, 4'd3, 10'd304, 10'd220));
        exp_q.push_back(rec(ST_PLAY,    3'd0, 4'd3, 10'd304, 10'd220));
        start = 1'b1; step(); start = 1'b0;
        check("respawn_after_start", {31'd0, respawn}, W'(1));
        step();
        check("play_unfrozen", {29'd0, game_state}, W'(ST_PLAY));
        idle(2);
        drained("start_seq");

        // Checkpoint then death: spawn follows the checkpoint
        char_x = 10'd500; char_y = 10'd300;
        cp_evt = 1'b1; step(); cp_evt = 1'b0;
        check("cp_spawn", {12'd0, spawn_x, spawn_y}, {12'd0, 10'd500, 10'd300});
        exp_q.push_back(rec(ST_DYING,   3'd0, 4'd2, 10'd500, 10'd300));
        exp_q.push_back(rec(ST_RESPAWN, 3'd0, 4'd2, 10'd500, 10'd300));
        exp_q.push_back(rec(ST_PLAY,    3'd0, 4'd2, 10'd500, 10'd300));
        death_evt = 1'b1; step(); death_evt = 1'b0;
        // events while dying must be ignored
        char_x = 10'd1; char_y = 10'd2;
        goal_evt = 1'b1; cp_evt = 1'b1; step(); goal_evt = 1'b0; cp_evt = 1'b0;
        ticks(29);
        check("dying_29_ticks", {29'd0, game_state}, W'(ST_DYING));
        ticks(1);
        idle(3);
        drained("death_seq");

        // death and goal together: death wins, level unchanged
        exp_q.push_back(rec(ST_DYING,   3'd0, 4'd1, 10'd500, 10'd300));
        exp_q.push_back(rec(ST_RESPAWN, 3'd0, 4'd1, 10'd500, 10'd300));
        exp_q.push_back(rec(ST_PLAY,    3'd0, 4'd1, 10'd500, 10'd300));
        death_evt = 1'b1; goal_evt = 1'b1; step(); death_evt = 1'b0; goal_evt = 1'b0;
        ticks(30);
        idle(3);
        drained("death_goal_seq");

        // goal at level 0 clears the checkpoint, 60 ticks in CLEAR
        exp_q.push_back(rec(ST_CLEAR,   3'd0, 4'd1, 10'd304, 10'd220));
        exp_q.push_back(rec(ST_RESPAWN, 3'd1, 4'd1, 10'd304, 10'd220));
        exp_q.push_back(rec(ST_PLAY,    3'd1, 4'd1, 10'd304, 10'd220));
        goal_evt = 1'b1; step(); goal_evt = 1'b0;
        ticks(59);
        check("clear_59_ticks", {29'd0, game_state}, W'(ST_CLEAR));
        ticks(1);
        idle(3);
        drained("clear_seq");

        // levels 1..6 to reach level 7
        for (int l = 1; l < 7; l++) begin
            exp_q.push_back(rec(ST_CLEAR,   3'(l),     4'd1, 10'd304, 10'd220));
            exp_q.push_back(rec(ST_RESPAWN, 3'(l + 1), 4'd1, 10'd304, 10'd220));
            exp_q.push_back(rec(ST_PLAY,    3'(l + 1), 4'd1, 10'd304, 10'd220));
            goal_evt = 1'b1; step(); goal_evt = 1'b0;
            ticks(60);
            idle(3);
        end
        drained("level_walk");

        // goal at last level -> WIN, hold until start
        exp_q.push_back(rec(ST_WIN, 3'd7, 4'd1, 10'd304, 10'd220));
        goal_evt = 1'b1; step(); goal_evt = 1'b0;
        idle(5);
        check("win_hold", {29'd0, game_state}, W'(ST_WIN));
        exp_q.push_back(rec(ST_IDLE, 3'd7, 4'd1, 10'd304, 10'd220));
        press_start();
        idle(2);
        drained("win_seq");

        // new game, three deaths -> OVER
        exp_q.push_back(rec(ST_RESPAWN, 3'd0, 4'd3, 10'd304, 10'd220));
        exp_q.push_back(rec(ST_PLAY,    3'd0, 4'd3, 10'd304, 10'd220));
        press_start();
        idle(2);
        for (int d = 2; d >= 0; d--) begin
            exp_q.push_back(rec(ST_DYING, 3'd0, 4'(d), 10'd304, 10'd220));
            if (d > 0) begin
                exp_q.push_back(rec(ST_RESPAWN, 3'd0, 4'(d), 10'd304, 10'd220));
                exp_q.push_back(rec(ST_PLAY,    3'd0, 4'(d), 10'd304, 10'd220));
            end else begin
                exp_q.push_back(rec(ST_OVER, 3'd0, 4'd0, 10'd304, 10'd220));
            end
            death_evt = 1'b1; step(); death_evt = 1'b0;
            ticks(30);
            idle(3);
        end
        check("over_lives", {28'd0, lives}, W'(0));
        exp_q.push_back(rec(ST_IDLE, 3'd0, 4'd0, 10'd304, 10'd220));
        press_start();
        idle(2);
        drained("over_seq");

        // reset in the middle of CLEAR
        exp_q.push_back(rec(ST_RESPAWN, 3'd0, 4'd3, 10'd304, 10'd220));
        exp_q.push_back(rec(ST_PLAY,    3'd0, 4'd3, 10'd304, 10'd220));
        exp_q.push_back(rec(ST_CLEAR,   3'd0, 4'd3, 10'd304, 10'd220));
        press_start();
        idle(2);
        goal_evt = 1'b1; step(); goal_evt = 1'b0;
        ticks(20);
        exp_q.push_back(rec(ST_IDLE, 3'd0, 4'd3, 10'd304, 10'd220));
        rst = 1'b0; step(); rst = 1'b1;
        check("reset_mid_clear", {26'd0, game_state, level, freeze}, {26'd0, ST_IDLE, 3'd0, 1'b1});
        idle(3);
        drained("reset_seq");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
